// File: rtl/led_anim_pkg.sv
// Shared mode codes and FSM state encodings for led_animator.
// The start-state helper keeps IDLE exit and mode re-latch on the same rule.
package led_anim_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_RUN_UP   = 2'b01,
    S_RUN_DOWN = 2'b10
  } state_e;

  function automatic state_e start_state(input mode_e m);
    return (m == MODE_DOWN) ? S_RUN_DOWN : S_RUN_UP;
  endfunction

endpackage

// File: rtl/led_anim_prescaler.sv
// Step-rate prescaler: counts up while not cleared and ticks when the count reaches div.
// Using >= lets a live decrease of div take effect without waiting for the counter to roll over.
module led_anim_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] presc_q, presc_d;

  assign tick = !clr && (presc_q >= div);

  always_comb begin
    presc_d = presc_q + DIV_W'(1);
    if (clr || tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/led_animator.sv
// LED animation sequencer: chase up/down, bounce and fill bar over N_LEDS, stepped by a prescaler.
// Define LED_ANIM_BLINK_EN to blink the active LED (off, then on, within each step period).
module led_animator
  import led_anim_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int DIV_W  = 16,
  parameter int POS_W  = $clog2(N_LEDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  output logic [N_LEDS-1:0] out,
  output logic [POS_W-1:0]  pos,
  output logic              wrap
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             wrap_q, wrap_d;

  logic             running;
  logic             tick;
  logic             step;
  logic             lit;
  logic [POS_W-1:0] step_pos;
  state_e           step_state;
  logic             step_wrap;

  function automatic logic [POS_W-1:0] start_pos(input mode_e m);
    return (m == MODE_DOWN) ? POS_MAX : {POS_W{1'b0}};
  endfunction

  assign running = (state_q == S_RUN_UP) || (state_q == S_RUN_DOWN);

  led_anim_prescaler #(
    .DIV_W(DIV_W)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (!running || !en),
    .div (div),
    .tick(tick)
  );

`ifdef LED_ANIM_BLINK_EN
  logic phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (!running || !en) begin
      phase_d = 1'b0;
    end else if (tick) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Only the second tick of each pair advances the pattern.
  assign step = tick && phase_q;
  assign lit  = phase_q;
`else
  assign step = tick;
  assign lit  = 1'b1;
`endif

  // Position/direction the pattern would move to on a step, before any mode re-latch.
  always_comb begin
    step_pos   = pos_q + POS_W'(1);
    step_state = state_q;
    step_wrap  = 1'b0;
    case (mode_q)
      MODE_DOWN: begin
        if (pos_q == '0) begin
          step_pos  = POS_MAX;
          step_wrap = 1'b1;
        end else begin
          step_pos = pos_q - POS_W'(1);
        end
      end
      MODE_BOUNCE: begin
        if (state_q == S_RUN_UP) begin
          if (pos_q == POS_MAX) begin
            step_state = S_RUN_DOWN;
            step_pos   = POS_MAX - POS_W'(1);
          end
        end else if (pos_q == '0) begin
          step_state = S_RUN_UP;
          step_pos   = POS_W'(1);
          step_wrap  = 1'b1;
        end else begin
          step_pos = pos_q - POS_W'(1);
        end
      end
      default: begin
        if (pos_q == POS_MAX) begin
          step_pos  = '0;
          step_wrap = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          mode_d  = mode_e'(mode);
          state_d = start_state(mode_d);
          pos_d   = start_pos(mode_d);
        end
      end
      S_RUN_UP, S_RUN_DOWN: begin
        if (!en) begin
          state_d = S_IDLE;
          pos_d   = '0;
        end else if (step) begin
          state_d = step_state;
          pos_d   = step_pos;
          wrap_d  = step_wrap;
          // A new mode is only accepted at the end of a full cycle, and restarts from its own start point.
          if (step_wrap) begin
            mode_d = mode_e'(mode);
            if (mode_d != mode_q) begin
              state_d = start_state(mode_d);
              pos_d   = start_pos(mode_d);
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        pos_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_UP;
      pos_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
    end
  end

  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led
    localparam logic [POS_W-1:0] IDX = POS_W'(gi);
    assign out[gi] = running &&
                     ((pos_q == IDX) ? lit : ((mode_q == MODE_FILL) && (IDX < pos_q)));
  end

  assign pos  = running ? pos_q : '0;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_animator.sv
// Self-checking bench for led_animator (default build): directed scenarios then random en/mode/div,
// compared every cycle against a cycle-list reference model of the animation.
module tb_led_animator;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int PW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] div  = '0;
  logic [N-1:0]  out;
  logic [PW-1:0] pos;
  logic          wrap;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: each mode is a fixed list of positions; a step advances the list index,
  // and stepping past the last entry back to entry 0 is the wrap. Bounce enters at index -1 (pos 0).
  bit run_m;
  int mode_m;
  int idx_m;
  int cnt_m;
  bit wrap_m;

  always #5 clk = ~clk;

  led_animator #(
    .N_LEDS(N),
    .DIV_W (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .div (div),
    .out (out),
    .pos (pos),
    .wrap(wrap)
  );

  function automatic int cyc_len(int m);
    return (m == 2) ? 2 * N - 2 : N;
  endfunction

  function automatic int entry_idx(int m);
    return (m == 2) ? -1 : 0;
  endfunction

  function automatic int pos_of(int m, int i);
    case (m)
      1:       return N - 1 - i;
      2:       return (i <= N - 2) ? i + 1 : 2 * N - 3 - i;
      default: return i;
    endcase
  endfunction

  function automatic logic [31:0] pattern_of(int m, int p);
    logic [63:0] v;
    if (m == 3) v = (64'd1 << (p + 1)) - 64'd1;
    else        v = 64'd1 << p;
    return v[31:0];
  endfunction

  task automatic model_reset();
    run_m  = 1'b0;
    wrap_m = 1'b0;
    mode_m = 0;
    idx_m  = 0;
    cnt_m  = 0;
  endtask

  task automatic model_edge();
    int nxt;
    wrap_m = 1'b0;
    if (!run_m) begin
      if (en) begin
        run_m  = 1'b1;
        mode_m = int'(mode);
        idx_m  = entry_idx(mode_m);
        cnt_m  = 0;
      end
    end else if (!en) begin
      run_m = 1'b0;
    end else if (cnt_m >= int'(div)) begin
      cnt_m = 0;
      nxt   = idx_m + 1;
      if (nxt == cyc_len(mode_m)) begin
        idx_m  = 0;
        wrap_m = 1'b1;
        if (int'(mode) != mode_m) begin
          mode_m = int'(mode);
          idx_m  = entry_idx(mode_m);
        end
      end else begin
        idx_m = nxt;
      end
    end else begin
      cnt_m++;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_pos;
    logic [31:0] exp_out;
    exp_pos = run_m ? 32'(pos_of(mode_m, idx_m)) : 32'd0;
    exp_out = run_m ? pattern_of(mode_m, pos_of(mode_m, idx_m)) : 32'd0;
    check("out", 32'(out), exp_out);
    check("pos", 32'(pos), exp_pos);
    check("wrap", 32'(wrap), 32'(wrap_m));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  // Called at posedge+1: asserts reset mid-cycle and checks outputs clear without a clock edge.
  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    $display("txn reset: out=%0h pos=%0d wrap=%0b", out, pos, wrap);

    mode = 2'b00; div = 3; en = 1'b1;
    run(40);
    $display("txn chase_up div=3: out=%0h pos=%0d", out, pos);

    en = 1'b0;
    run(2);
    mode = 2'b10; div = 0; en = 1'b1;
    run(32);
    $display("txn bounce div=0: out=%0h pos=%0d", out, pos);

    en = 1'b0;
    run(1);
    mode = 2'b11; div = 1; en = 1'b1;
    run(6);
    mode = 2'b01;
    run(34);
    $display("txn fill then down: out=%0h pos=%0d", out, pos);

    en = 1'b0;
    run(1);
    mode = 2'b00; div = 0; en = 1'b1;
    run(6);
    check("pos_before_drop", 32'(pos), 32'd5);
    en = 1'b0;
    run(2);
    en = 1'b1;
    run(3);
    $display("txn en drop/restart: out=%0h pos=%0d", out, pos);

    div = 5;
    en = 1'b0;
    run(1);
    en = 1'b1;
    run(3);
    async_reset();
    $display("txn async reset: out=%0h pos=%0d wrap=%0b", out, pos, wrap);

    div = 10;
    run(7);
    div = 2;
    run(4);
    $display("txn live div decrease: out=%0h pos=%0d", out, pos);

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) div = DW'($urandom_range(0, 4));
      run(1);
    end
    $display("txn random 3000 cycles: out=%0h pos=%0d", out, pos);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
